// File: rtl/audio_pkg.sv
// Shared Q15 constants and the overlap-add state enum for the audio synthesis path.
package audio_pkg;

    localparam int unsigned Q         = 15;
    localparam logic [15:0] COLA_GAIN = 16'h7684;
    localparam logic [15:0] SAT_MAX   = 16'h7FFF;
    localparam logic [15:0] SAT_MIN   = 16'h8000;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

endpackage

// File: rtl/q15_mac_sat.sv
// Combinational Q15 (a + b) * gain with arithmetic rescale and saturation.
module q15_mac_sat
#(
    parameter int unsigned    DW   = 16,
    parameter logic [DW-1:0]  GAIN = DW'(16'h7684)
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] result_c
);
    import audio_pkg::*;

    localparam int unsigned SW = DW + 1;
    localparam int unsigned PW = 2 * DW + 1;
    localparam logic signed [PW-1:0] MAX_V = PW'($signed(DW'(SAT_MAX)));
    localparam logic signed [PW-1:0] MIN_V = PW'($signed(DW'(SAT_MIN)));

    logic signed [SW-1:0] sum;
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] shifted;

    // Gain is a non-negative Q15 factor, so it is zero-extended before the signed multiply.
    always_comb begin
        sum     = SW'($signed(a)) + SW'($signed(b));
        prod    = PW'(sum) * PW'($signed({1'b0, GAIN}));
        shifted = prod >>> Q;
        if (shifted > MAX_V) begin
            result_c = DW'(SAT_MAX);
        end else if (shifted < MIN_V) begin
            result_c = DW'(SAT_MIN);
        end else begin
            result_c = shifted[DW-1:0];
        end
    end

endmodule

// File: rtl/overlap_add_synth.sv
// 50% overlap-add reconstruction of windowed Q15 frames with Hamming COLA normalisation.
module overlap_add_synth
#(
    parameter int unsigned   N         = 256,
    parameter int unsigned   HOP       = N / 2,
    parameter int unsigned   DW        = 16,
    parameter logic [DW-1:0] COLA_GAIN = DW'(audio_pkg::COLA_GAIN)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] frame_in,
    input  logic          frame_in_valid,
    input  logic          frame_in_last,
    output logic          frame_in_ready,
    input  logic          flush,
    output logic [DW-1:0] sample_out,
    output logic          sample_out_valid,
    input  logic          sample_out_ready,
    output logic          busy,
    output logic          frame_err
);
    import audio_pkg::*;

    if (HOP != N / 2 || (N % 2) != 0) begin : g_bad_cfg
        $error("overlap_add_synth: N must be even and HOP must equal N/2");
    end

    localparam int unsigned IW     = $clog2(N);
    localparam int unsigned AW     = $clog2(HOP);
    localparam logic [IW-1:0] HOP_I  = IW'(HOP);
    localparam logic [IW-1:0] LAST_I = IW'(N - 1);

    state_t        state, state_nxt;
    logic [IW-1:0] idx, idx_nxt;
    logic          tail_valid, tail_valid_nxt;
    logic [DW-1:0] sample_out_nxt;
    logic          sample_out_valid_nxt;
    logic          frame_err_nxt;

    logic [DW-1:0] tail_mem [HOP];
    logic [AW-1:0] tail_addr_c;
    logic [DW-1:0] tail_rd_c;
    logic          tail_we_c;
    logic [DW-1:0] mac_a_c, mac_b_c, mac_c;
    logic          accumulate_c, flush_go_c, in_xfer_c, can_load_c;

    // One address serves both the accumulate read and the store write; they never coincide.
    always_comb begin
        accumulate_c = idx < HOP_I;
        if (state == RUN && !accumulate_c) begin
            tail_addr_c = AW'(idx - HOP_I);
        end else begin
            tail_addr_c = AW'(idx);
        end
        tail_rd_c = tail_mem[tail_addr_c];
        mac_a_c   = (state == FLUSH) ? tail_rd_c : frame_in;
        mac_b_c   = (state == RUN && tail_valid) ? tail_rd_c : '0;
    end

    always_ff @(posedge clk) begin
        if (tail_we_c) begin
            tail_mem[tail_addr_c] <= frame_in;
        end
    end

    q15_mac_sat #(
        .DW   (DW),
        .GAIN (COLA_GAIN)
    ) u_mac (
        .a        (mac_a_c),
        .b        (mac_b_c),
        .result_c (mac_c)
    );

    always_comb begin
        state_nxt            = state;
        idx_nxt              = idx;
        tail_valid_nxt       = tail_valid;
        sample_out_nxt       = sample_out;
        sample_out_valid_nxt = sample_out_valid && !sample_out_ready;
        frame_err_nxt        = 1'b0;
        tail_we_c            = 1'b0;
        frame_in_ready       = 1'b0;
        flush_go_c           = 1'b0;
        in_xfer_c            = 1'b0;
        can_load_c           = !sample_out_valid || sample_out_ready;

        case (state)
            RUN: begin
                flush_go_c = flush && (idx == '0) && tail_valid;
                if (flush_go_c) begin
                    state_nxt = FLUSH;
                    idx_nxt   = '0;
                end else begin
                    frame_in_ready = accumulate_c ? can_load_c : 1'b1;
                end
                in_xfer_c = frame_in_valid && frame_in_ready;
                if (in_xfer_c) begin
                    if (accumulate_c) begin
                        sample_out_nxt       = mac_c;
                        sample_out_valid_nxt = 1'b1;
                    end else begin
                        tail_we_c = 1'b1;
                    end
                    // A misplaced or missing last marker is reported but never stalls the stream.
                    if (idx == LAST_I) begin
                        idx_nxt        = '0;
                        tail_valid_nxt = 1'b1;
                        frame_err_nxt  = !frame_in_last;
                    end else if (frame_in_last) begin
                        idx_nxt        = '0;
                        tail_valid_nxt = 1'b0;
                        frame_err_nxt  = 1'b1;
                    end else begin
                        idx_nxt = idx + IW'(1);
                    end
                end
            end
            FLUSH: begin
                // idx counts emitted tail samples; leave only once the last one has drained.
                if (can_load_c) begin
                    if (accumulate_c) begin
                        sample_out_nxt       = mac_c;
                        sample_out_valid_nxt = 1'b1;
                        idx_nxt              = idx + IW'(1);
                    end else begin
                        state_nxt      = RUN;
                        idx_nxt        = '0;
                        tail_valid_nxt = 1'b0;
                    end
                end
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= RUN;
            idx              <= '0;
            tail_valid       <= 1'b0;
            sample_out       <= '0;
            sample_out_valid <= 1'b0;
            frame_err        <= 1'b0;
        end else begin
            state            <= state_nxt;
            idx              <= idx_nxt;
            tail_valid       <= tail_valid_nxt;
            sample_out       <= sample_out_nxt;
            sample_out_valid <= sample_out_valid_nxt;
            frame_err        <= frame_err_nxt;
        end
    end

    assign busy = (state == FLUSH);

endmodule

// File: tb/tb_overlap_add_synth.sv
// Randomised bench for overlap_add_synth against a stream-level overlap-add model.
module tb_overlap_add_synth;

    localparam int N   = 256;
    localparam int HOP = 128;
    localparam longint GAIN = 30340;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] frame_in;
    logic        frame_in_valid;
    logic        frame_in_last;
    logic        frame_in_ready;
    logic        flush;
    logic [15:0] sample_out;
    logic        sample_out_valid;
    logic        sample_out_ready;
    logic        busy;
    logic        frame_err;

    always #5 clk = ~clk;

    overlap_add_synth dut (
        .clk              (clk),
        .rst              (rst),
        .frame_in         (frame_in),
        .frame_in_valid   (frame_in_valid),
        .frame_in_last    (frame_in_last),
        .frame_in_ready   (frame_in_ready),
        .flush            (flush),
        .sample_out       (sample_out),
        .sample_out_valid (sample_out_valid),
        .sample_out_ready (sample_out_ready),
        .busy             (busy),
        .frame_err        (frame_err)
    );

    int errors = 0;
    int checks = 0;

    logic [15:0] exp_q[$];
    logic [15:0] m_tail[HOP];
    bit          m_tv, m_flushing, m_err;
    int          m_pos;
    bit          mon_en = 1'b0;
    bit          lit_en = 1'b0;
    logic [15:0] lit_val = 16'h0;
    int          out_cnt = 0;
    int          err_cnt = 0;
    int          rdy_mode = 0;
    bit          gap_en = 1'b0;
    bit          stalled = 1'b0;
    logic [15:0] stall_val;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: saturate(((x + y) * gain) >>> 15) in plain integer arithmetic.
    function automatic logic [15:0] model_out(input int x, input int y);
        longint p;
        longint s;
        p = longint'(x + y) * GAIN;
        s = p >>> 15;
        if (s > 32767) return 16'h7FFF;
        if (s < -32768) return 16'h8000;
        return 16'(s);
    endfunction

    initial begin
        sample_out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0:       sample_out_ready = 1'b1;
                2:       sample_out_ready = 1'b0;
                default: sample_out_ready = 1'($urandom_range(1));
            endcase
        end
    end

    // Model state reflects the DUT after the previous edge; events decide the next edge.
    bit          in_x, out_x, fgo, exp_rdy;
    logic [15:0] e;
    always @(negedge clk) begin
        if (mon_en) begin
            check("frame_err", frame_err, m_err);
            if (frame_err) err_cnt++;
            check("busy", busy, m_flushing);
            if (stalled) begin
                check("stall_valid", sample_out_valid, 1'b1);
                check("stall_hold", sample_out, stall_val);
            end
            fgo = flush && m_pos == 0 && !m_flushing && m_tv;
            if (m_flushing || fgo) exp_rdy = 1'b0;
            else if (m_pos < HOP)  exp_rdy = !sample_out_valid || sample_out_ready;
            else                   exp_rdy = 1'b1;
            check("frame_in_ready", frame_in_ready, exp_rdy);

            in_x      = frame_in_valid && frame_in_ready;
            out_x     = sample_out_valid && sample_out_ready;
            stalled   = sample_out_valid && !sample_out_ready;
            stall_val = sample_out;
            m_err     = 1'b0;

            if (out_x) begin
                out_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_output", sample_out, 16'hxxxx);
                end else begin
                    e = exp_q.pop_front();
                    check("sample_out", sample_out, e);
                    if (lit_en) check("sample_literal", sample_out, lit_val);
                end
                if (m_flushing && exp_q.size() == 0) m_flushing = 1'b0;
            end

            if (fgo) begin
                for (int k = 0; k < HOP; k++)
                    exp_q.push_back(model_out(int'($signed(m_tail[k])), 0));
                m_flushing = 1'b1;
                m_tv       = 1'b0;
            end

            if (in_x) begin
                if (m_pos < HOP)
                    exp_q.push_back(model_out(int'($signed(frame_in)),
                                              m_tv ? int'($signed(m_tail[m_pos])) : 0));
                else
                    m_tail[m_pos - HOP] = frame_in;
                if (m_pos == N - 1) begin
                    m_err = !frame_in_last;
                    m_pos = 0;
                    m_tv  = 1'b1;
                end else if (frame_in_last) begin
                    m_err = 1'b1;
                    m_pos = 0;
                    m_tv  = 1'b0;
                end else begin
                    m_pos++;
                end
            end
        end
    end

    task automatic send_sample(input logic [15:0] d, input bit l, input bit fl);
        bit acc;
        int t;
        t = 0;
        frame_in       = d;
        frame_in_last  = l;
        frame_in_valid = 1'b1;
        flush          = fl;
        forever begin
            @(negedge clk);
            acc = frame_in_ready;
            @(posedge clk);
            #1;
            flush = 1'b0;
            if (acc) break;
            t++;
            if (t > 1000) begin
                check("input_accept_timeout", 32'(t), 32'd0);
                break;
            end
        end
        frame_in_valid = 1'b0;
        frame_in_last  = 1'b0;
        if (gap_en && $urandom_range(3) == 0) begin
            @(posedge clk);
            #1;
        end
    endtask

    // last_at >= N means the frame ends without a last marker; flush_at < 0 means no flush.
    task automatic send_frame(input bit rnd, input logic [15:0] val, input int last_at, input int flush_at);
        int stop;
        stop = (last_at < N) ? last_at : N - 1;
        for (int i = 0; i <= stop; i++)
            send_sample(rnd ? 16'($urandom) : val, i == last_at, i == flush_at);
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 || m_flushing || sample_out_valid) begin
            @(posedge clk);
            #1;
            t++;
            if (t > 3000) begin
                check("drain_timeout", 32'(exp_q.size()), 32'd0);
                break;
            end
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

    int c0, e0;
    initial begin
        rst = 1'b1;
        frame_in = '0;
        frame_in_valid = 1'b0;
        frame_in_last = 1'b0;
        flush = 1'b0;
        m_tv = 1'b0;
        m_flushing = 1'b0;
        m_err = 1'b0;
        m_pos = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_sample_out", sample_out, 16'h0000);
        check("reset_valid", sample_out_valid, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_frame_err", frame_err, 1'b0);
        rst = 1'b0;
        mon_en = 1'b1;

        // First frame: no tail, 0x4000 * gain.
        lit_en = 1'b1; lit_val = 16'h3B42;
        c0 = out_cnt; e0 = err_cnt;
        send_frame(1'b0, 16'h4000, N - 1, -1);
        wait_drain();
        check("frame1_count", 32'(out_cnt - c0), 32'd128);
        check("frame1_err", 32'(err_cnt - e0), 32'd0);

        // Second frame: sum 0x8000 * gain.
        lit_val = 16'h7684;
        c0 = out_cnt;
        send_frame(1'b0, 16'h4000, N - 1, -1);
        wait_drain();
        check("frame2_count", 32'(out_cnt - c0), 32'd128);

        // Flush the stored tail, then a second flush is a no-op.
        lit_val = 16'h3B42;
        c0 = out_cnt;
        do_flush();
        wait_drain();
        check("flush_count", 32'(out_cnt - c0), 32'd128);
        c0 = out_cnt;
        do_flush();
        repeat (20) @(posedge clk);
        #1;
        check("flush_again_count", 32'(out_cnt - c0), 32'd0);
        check("flush_again_busy", busy, 1'b0);

        // Positive and negative saturation.
        lit_en = 1'b0;
        send_frame(1'b0, 16'h7FFF, N - 1, -1);
        lit_en = 1'b1; lit_val = 16'h7FFF;
        send_frame(1'b0, 16'h7FFF, N - 1, -1);
        wait_drain();
        lit_en = 1'b0;
        send_frame(1'b0, 16'h8000, N - 1, -1);
        lit_en = 1'b1; lit_val = 16'h8000;
        send_frame(1'b0, 16'h8000, N - 1, -1);
        wait_drain();

        // Early last at idx 100, then a frame without tail while output stalls 10 cycles.
        lit_en = 1'b1; lit_val = 16'hC4BE;
        e0 = err_cnt;
        send_frame(1'b0, 16'h4000, 100, -1);
        wait_drain();
        check("early_last_err_pulses", 32'(err_cnt - e0), 32'd1);
        lit_val = 16'h3B42;
        c0 = out_cnt;
        fork
            send_frame(1'b0, 16'h4000, N - 1, -1);
            begin
                repeat (40) @(posedge clk);
                #1;
                rdy_mode = 2;
                repeat (5) @(posedge clk);
                #3;
                check("stall_in_ready", frame_in_ready, 1'b0);
                check("stall_out_valid", sample_out_valid, 1'b1);
                repeat (5) @(posedge clk);
                #1;
                rdy_mode = 0;
            end
        join
        wait_drain();
        check("post_err_count", 32'(out_cnt - c0), 32'd128);

        // Random data, random backpressure and gaps, random framing and flush placement.
        lit_en = 1'b0;
        rdy_mode = 1;
        gap_en = 1'b1;
        for (int f = 0; f < 10; f++) begin
            int r, la, fa;
            r  = int'($urandom_range(9));
            la = (r == 0) ? int'($urandom_range(N - 2)) : (r == 1) ? N : N - 1;
            r  = int'($urandom_range(3));
            fa = (r == 0) ? 0 : (r == 1) ? int'($urandom_range(N - 1)) : -1;
            send_frame(1'b1, 16'h0, la, fa);
            if ($urandom_range(4) == 0) do_flush();
        end
        wait_drain();
        rdy_mode = 0;
        gap_en = 1'b0;
        do_flush();
        wait_drain();
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/overlap_add_synth.md
Name: overlap_add_synth

Overview:
- Synthesis-side counterpart of the analysis Hamming window in the audio front end.
- Accepts a stream of windowed frames of N signed Q15 samples, for example from the inverse-transform path.
- Reconstructs a continuous sample stream by 50 % overlap-add, normalised by the Hamming COLA gain.
- Sits after the IFFT and before the audio/DAC sink.

Parameters:
- N, 256, frame length in samples; must be even.
- HOP, N/2, hop size; fixed at N/2, and elaboration fails otherwise.
- DW, 16, sample width (signed Q15).
- COLA_GAIN, 16'h7684, normalisation factor 1/1.08 in Q15 (≈0.9259).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- frame_in  in  DW  windowed sample, signed Q15
- frame_in_valid  in  1  frame_in valid
- frame_in_last  in  1  marks sample N-1 of a frame
- frame_in_ready  out  1  block accepts frame_in this cycle
- flush  in  1  single-cycle pulse: drain the stored tail
- sample_out  out  DW  reconstructed sample, signed Q15
- sample_out_valid  out  1  sample_out valid
- sample_out_ready  in  1  downstream accepts sample_out
- busy  out  1  high during FLUSH
- frame_err  out  1  one-cycle pulse on a framing error

Behaviour:
- Reset (synchronous, active-high):
  - sample_out=0, sample_out_valid=0, busy=0, frame_err=0.
  - idx=0, tail_valid=0, state=RUN.
  - Tail RAM contents are don't-care; tail_valid=0 makes them read as zero.
  - Reset mid-frame or mid-flush abandons all data.
- Transfer rules:
  - Input transfer occurs when frame_in_valid && frame_in_ready.
  - Output transfer occurs when sample_out_valid && sample_out_ready.
  - sample_out and sample_out_valid hold steady until transferred.
- Storage: tail[0..HOP-1] holds the second half of the previous frame; idx in [0, N-1] is the position in the current frame.
- RUN, idx < HOP (accumulate):
  - frame_in_ready = !sample_out_valid || sample_out_ready.
  - On transfer: sum = frame_in + (tail_valid ? tail[idx] : 0), 17-bit signed.
  - prod = sum * COLA_GAIN, 33-bit signed.
  - out = saturate(prod >>> 15) to [0x8000, 0x7FFF].
  - out is registered into sample_out, so latency is 1 cycle from input transfer to sample_out_valid.
- RUN, idx >= HOP (store):
  - frame_in_ready = 1.
  - tail[idx-HOP] <= frame_in; no output produced.
  - A pending sample_out may still drain.
- End of frame:
  - At idx=N-1 the transfer sets tail_valid=1 and idx=0.
- Framing errors:
  - frame_in_last asserted at idx != N-1: the sample is processed normally, frame_err pulses, then idx=0 and tail_valid=0.
  - frame_in_last low at idx=N-1: frame_err pulses; idx wraps to 0 and tail_valid=1 as normal.
- flush:
  - Sampled in RUN only when idx=0; otherwise ignored (no error).
  - If tail_valid=0, flush is a no-op.
  - Else enter FLUSH: busy=1, frame_in_ready=0.
  - Emit HOP samples out = saturate((tail[k] * COLA_GAIN) >>> 15), k=0..HOP-1, one per output transfer.
  - Then tail_valid=0, busy=0, return to RUN.
- Simultaneous flush and frame_in_valid at idx=0: flush wins; the input waits because ready=0.
- Throughput: 1 sample/cycle in accumulate phase without backpressure; HOP outputs per N inputs.

Decomposition:
- Shared package audio_pkg holds:
  - Q15 constants: COLA_GAIN, Q=15, SAT_MAX=16'h7FFF, SAT_MIN=16'h8000.
  - State enum {RUN, FLUSH}.
- One sub-module, q15_mac_sat: (a + b) * gain, arithmetic shift, saturate; combinational with registered output in the parent.
- Tail storage is an inferred single-port HOP×DW RAM inside the parent.

Test Plan:
- Reset, then one frame of all 16'h4000 (last on sample 255) → 128 outputs of 16'h3B42; no output for samples 128–255; frame_err=0.
- Second frame of all 16'h4000 → 128 outputs of 16'h7684 (sum 0x8000 × gain).
- Two frames of 16'h7FFF → second-frame outputs saturate to 16'h7FFF; two frames of 16'h8000 → outputs 16'h8000.
- After one frame of 16'h4000, pulse flush → busy high, 128 outputs of 16'h3B42, frame_in_ready=0 throughout, then busy low; a following flush produces nothing.
- Hold sample_out_ready=0 for 10 cycles mid-accumulate → sample_out stable, frame_in_ready=0, no sample lost or duplicated; output sequence matches the reference model.
- frame_in_last at idx=100 → frame_err one-cycle pulse; the next frame's first half is output without tail addition (all 16'h4000 in → 16'h3B42).
